inst_fetch: RTL
===============

// Module: inst_fetch
// PURPOSE
// - Instruction fetch stage of the single-cycle MIPS-style core: holds the PC, fetches one 32-bit word
//   per instruction from a ready-handshaked instruction memory, and presents instr/opcode to the control
//   and decode logic.
// - Consumes branch/jump from control plus ALU zero on instruction retire to select the next PC.
// - Sits directly upstream of control; its opcode output drives control.opcode.
// PARAMETERS
// - RESET_PC   32'h0000_0000   PC value loaded on reset (word aligned)
// - ADDR_W     32              PC / imem address width
// - INSTR_W    32              instruction width (fixed 32; parameter for package consistency)
// PORTS
// - clk          in   1        rising-edge clock
// - reset        in   1        asynchronous, active-low reset
// - imem_req     out  1        fetch request; held high until imem_ready
// - imem_addr    out  ADDR_W   fetch byte address (= pc)
// - imem_ready   in   1        imem_rdata valid this cycle; request completes
// - imem_rdata   in   INSTR_W  fetched instruction word
// - instr        out  INSTR_W  current instruction (registered)
// - opcode       out  6        instr[31:26], to control
// - instr_valid  out  1        instr holds a fetched instruction awaiting retire
// - pc           out  ADDR_W   address of current instruction
// - retire       in   1        downstream completes current instruction this cycle
// - branch       in   1        from control
// - jump         in   1        from control
// - zero         in   1        ALU zero flag
// - instr_count  out  32       retired-instruction counter
// BEHAVIOUR
// - Reset (reset=0, async): pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, instr_count=0, state=BOOT.
// - FSM: BOOT -> FETCH (first clk after reset deasserts). FETCH: imem_req=1, imem_addr=pc; on imem_ready
//   latch instr<=imem_rdata, instr_valid<=1, -> EXEC. EXEC: imem_req=0; hold instr stable; on retire:
//   pc<=next_pc, instr_valid<=0, instr_count<=instr_count+1, -> FETCH.
// - Latency: imem_ready in cycle N -> instr_valid=1 in N+1. retire in cycle M -> imem_req=1 at pc=next_pc in M+1.
//   Minimum 2 cycles per instruction with zero-wait imem.
// - imem_ready may assert in the same cycle imem_req first rises; imem_ready while not in FETCH is ignored.
// - retire while instr_valid=0 is ignored (no pc change, no count).
// - branch/jump/zero sampled only in the retire cycle.
// - next_pc (pc_plus4 = pc+4, modulo 2^ADDR_W, wraps 32'hFFFF_FFFC -> 0):
//   jump=1                 -> {pc_plus4[31:28], instr[25:0], 2'b00}  (jump has priority; control
//                             drives branch=1 with jump)
//   branch=1 & zero=1      -> pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00})
//   otherwise              -> pc_plus4
//   Branch add wraps modulo 2^ADDR_W; pc[1:0] always 00.
// - instr_count wraps 32'hFFFF_FFFF -> 0.
// - Reset mid-fetch or mid-EXEC: outstanding request abandoned, all outputs return to reset values
//   immediately; any late imem_ready after reset is ignored until next FETCH.
// - opcode is combinational slice of registered instr; while instr_valid=0 it reflects last instr (0 after reset).
// STRUCTURE
// - Shared package: fetch state enum (BOOT, FETCH, EXEC), opcode constants (R-type 6'h00, J 6'h02,
//   BEQ 6'h04, ADDI 6'h08, ANDI 6'h0C, LW 6'h23, SW 6'h2B, SHIFT 6'h30), INSTR_W, RESET_PC default.
// - One sub-module: next_pc_logic (combinational: pc, instr, branch, jump, zero -> next_pc).
// - Top: FSM, pc/instr/instr_count registers, imem handshake.
// TESTING
// - Reset release, zero-wait imem returning 32'h2008_0005 -> imem_addr=0, instr_valid next cycle,
//   opcode=6'h08; retire -> imem_addr=4, instr_count=1.
// - imem_ready delayed 3 cycles -> imem_req/imem_addr held constant for all 4 cycles, instr_valid only after.
// - pc=0x40, instr=32'h1000_FFFE, branch=1, zero=1, retire -> next imem_addr=0x3C; same with zero=0 -> 0x44.
// - pc=0x1000_0010, instr=32'h0800_0100, jump=1, branch=1, retire -> imem_addr=0x1000_0400.
// - pc=32'hFFFF_FFFC sequential retire -> imem_addr=0; instr_count preset-to-FFFF_FFFF via retires wraps to 0.
// - reset asserted mid-EXEC and during FETCH wait -> same cycle: instr_valid=0, imem_req=0, pc=RESET_PC;
//   stray imem_ready afterwards has no effect; retire with instr_valid=0 leaves pc/count unchanged.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned OPCODE_W  = 6;
  localparam int unsigned COUNT_W   = 32;
  localparam int unsigned JIDX_W    = 26;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch sequencing: BOOT is a one-cycle settle after reset release.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_e;

  // Primary opcodes decoded by control.
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OPCODE_W-1:0] OP_SHIFT = 6'h30;

endpackage

// File: rtl/inst_fetch_next_pc_logic.sv
// Next-PC selection: jump target, taken branch, or sequential pc+4.
module next_pc_logic
  import inst_fetch_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic [PC_W-1:0]   pc,
  input  logic [JIDX_W-1:0] target,
  input  logic              branch,
  input  logic              jump,
  input  logic              zero,
  output logic [PC_W-1:0]   next_pc_c
);

  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] jump_pc;
  logic [PC_W-1:0] branch_pc;

  // Candidate targets; all adds wrap modulo 2^PC_W.
  always_comb begin
    pc_plus4  = pc + PC_W'(4);
    br_off    = {{(PC_W - 18){target[15]}}, target[15:0], 2'b00};
    branch_pc = pc_plus4 + br_off;
    jump_pc   = {pc_plus4[PC_W-1:28], target, 2'b00};
  end

  // Jump outranks branch because control raises branch alongside jump.
  always_comb begin
    next_pc_c = pc_plus4;
    if (jump) begin
      next_pc_c = jump_pc;
    end else if (branch && zero) begin
      next_pc_c = branch_pc;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, imem handshake, current instruction and retire count.
module inst_fetch
#(
  parameter int unsigned ADDR_W   = inst_fetch_pkg::ADDR_W,
  parameter int unsigned INSTR_W  = inst_fetch_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(inst_fetch_pkg::RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  input  logic               retire,
  input  logic               branch,
  input  logic               jump,
  input  logic               zero,
  output logic [31:0]        instr_count
);

  import inst_fetch_pkg::*;

  fetch_state_e    state;
  fetch_state_e    state_nxt;
  logic            load_instr;
  logic            do_retire;
  logic [ADDR_W-1:0] next_pc_c;

  next_pc_logic #(
    .PC_W (ADDR_W)
  ) u_next_pc (
    .pc        (pc),
    .target    (instr[JIDX_W-1:0]),
    .branch    (branch),
    .jump      (jump),
    .zero      (zero),
    .next_pc_c (next_pc_c)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath strobes; ready outside FETCH and retire outside EXEC are ignored.
  always_comb begin
    state_nxt  = state;
    load_instr = 1'b0;
    do_retire  = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          load_instr = 1'b1;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        if (retire) begin
          do_retire = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  // PC, instruction, request and retire counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      instr_count <= '0;
    end else begin
      imem_req <= (state_nxt == FETCH);
      if (load_instr) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (do_retire) begin
        pc          <= next_pc_c;
        instr_valid <= 1'b0;
        instr_count <= instr_count + 32'd1;
      end
    end
  end

  assign imem_addr = pc;
  assign opcode    = instr[INSTR_W-1 -: OPCODE_W];

endmodule
